// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Each op is granted, its operands are held in registers for one evaluation
// cycle, and the captured result is returned over a valid/ready channel.
module alu_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_aluop,
  input  logic [NREQ-1:0]   req_funct7,
  input  logic [3*NREQ-1:0] req_funct3,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [1:0]        alu_aluop,
  output logic              alu_funct7,
  output logic [2:0]        alu_funct3,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_zero,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_zero
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] owner_q;
  logic [PW-1:0] win;
  logic          found;

  // Winner search starts just after the last served requester.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StExec;
        end
        // Gated by rst_n so no grant is advertised while reset is held.
        if (rst_n && found) begin
          req_ready[win] = 1'b1;
        end
      end
      StExec: begin
        state_d = StResp;
      end
      StResp: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, operand capture, result capture and pointer rotation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= PW'(NREQ - 1);
      owner_q    <= '0;
      alu_aluop  <= '0;
      alu_funct7 <= 1'b0;
      alu_funct3 <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && found) begin
        alu_aluop  <= req_aluop[2*win +: 2];
        alu_funct7 <= req_funct7[win];
        alu_funct3 <= req_funct3[3*win +: 3];
        alu_a      <= req_a[W*win +: W];
        alu_b      <= req_b[W*win +: W];
        owner_q    <= win;
      end
      if (state_q == StExec) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
      if (state_q == StResp && rsp_ready[owner_q]) begin
        ptr_q <= owner_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with two requesters and a behavioural ALU.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_aluop;
  logic [NREQ-1:0]   req_funct7;
  logic [3*NREQ-1:0] req_funct3;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [1:0]        alu_aluop;
  logic              alu_funct7;
  logic [2:0]        alu_funct3;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [W-1:0]      alu_result;
  logic              alu_zero;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_result;
  logic              rsp_zero;

  typedef struct packed {
    logic [1:0]  oh;
    logic [31:0] res;
    logic        z;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  int  vectors = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_aluop  (req_aluop),
    .req_funct7 (req_funct7),
    .req_funct3 (req_funct3),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_aluop  (alu_aluop),
    .alu_funct7 (alu_funct7),
    .alu_funct3 (alu_funct3),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  function automatic logic [31:0] alu_f(input logic [1:0] op, input logic f7,
                                        input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      default: begin
        case (f3)
          3'b000:  return f7 ? a - b : a + b;
          3'b111:  return a & b;
          3'b110:  return a | b;
          3'b100:  return a ^ b;
          default: return a + b;
        endcase
      end
    endcase
  endfunction

  // Shared ALU stand-in: combinational from the arbiter's alu_* outputs.
  always_comb begin
    alu_result = alu_f(alu_aluop, alu_funct7, alu_funct3, alu_a, alu_b);
    alu_zero   = (alu_result == '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [1:0] op, input logic f7,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    req_aluop[2*idx +: 2]  = op;
    req_funct7[idx]        = f7;
    req_funct3[3*idx +: 3] = f3;
    req_a[W*idx +: W]      = a;
    req_b[W*idx +: W]      = b;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    set_req(0, 2'b10, 1'b0, 3'b000, 32'd5, 32'd7);
    set_req(1, 2'b01, 1'b0, 3'b000, 32'd9, 32'd9);
    repeat (2) step();
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_req_ready: got %b expected 00", req_ready);
    end
    vectors++;
    if (rsp_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid);
    end
    vectors++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_alu_ab: got a=%h b=%h expected 0", alu_a, alu_b);
    end
    vectors++;
    if ({alu_aluop, alu_funct7, alu_funct3} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_alu_ctl: got %b expected 0", {alu_aluop, alu_funct7, alu_funct3});
    end
    vectors++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rsp: got %h/%b expected 0/0", rsp_result, rsp_zero);
    end
    step();
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
  endtask

  // Issue one op alone, check latency, hold the response for 'hold' cycles, then take it.
  task automatic run_op(input string nm, input int idx, input logic [1:0] op, input logic f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic [31:0] exp_res, input logic exp_z);
    logic [1:0] oh;
    oh = 2'(1 << idx);
    step();
    set_req(idx, op, f7, f3, a, b);
    req_valid[idx] = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== oh) begin
      miscompares++;
      $display("FAIL %s_grant: got %b expected %b", nm, req_ready, oh);
    end
    sb.push_back('{oh: oh, res: exp_res, z: exp_z});
    step();
    req_valid[idx] = 1'b0;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 2'b00 || alu_a !== a || alu_b !== b) begin
      miscompares++;
      $display("FAIL %s_exec: got valid=%b a=%h b=%h expected 00 %h %h", nm, rsp_valid,
               alu_a, alu_b, a, b);
    end
    step();
    @(negedge clk);
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s_sb_empty: got no entry expected one", nm);
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== e.oh || rsp_result !== e.res || rsp_zero !== e.z) begin
        miscompares++;
        $display("FAIL %s_rsp: got valid=%b result=%h zero=%b expected %b %h %b", nm,
                 rsp_valid, rsp_result, rsp_zero, e.oh, e.res, e.z);
      end
    end
    for (int i = 0; i < hold; i++) begin
      step();
      @(negedge clk);
      vectors++;
      if (rsp_valid !== oh || rsp_result !== exp_res || rsp_zero !== exp_z || alu_a !== a) begin
        miscompares++;
        $display("FAIL %s_hold: got valid=%b result=%h zero=%b a=%h expected %b %h %b %h", nm,
                 rsp_valid, rsp_result, rsp_zero, alu_a, oh, exp_res, exp_z, a);
      end
    end
    step();
    rsp_ready = oh;
    step();
    rsp_ready = '0;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_done: got valid=%b expected 00", nm, rsp_valid);
    end
  endtask

  task automatic test_single();
    run_op("add", 0, 2'b10, 1'b0, 3'b000, 32'd5, 32'd7, 4, 32'd12, 1'b0);
  endtask

  task automatic test_branch();
    run_op("beq", 1, 2'b01, 1'b0, 3'b000, 32'd9, 32'd9, 1, 32'd0, 1'b1);
    run_op("sub", 0, 2'b10, 1'b1, 3'b000, 32'd3, 32'd10, 0, 32'hFFFF_FFF9, 1'b0);
    run_op("and", 1, 2'b10, 1'b0, 3'b111, 32'h0000_F0F0, 32'h0000_0F0F, 0, 32'd0, 1'b1);
  endtask

  task automatic test_round_robin();
    int g;
    int last;
    logic [1:0] exp_oh;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 2'b00, 1'b0, 3'b000, 32'd3, 32'd4);
    set_req(1, 2'b10, 1'b0, 3'b111, 32'h0000_F0F0, 32'h0000_FF00);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    g    = 0;
    last = -1;
    for (int c = 0; c < 20 && g < 4; c++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        exp_oh = (g % 2 == 0) ? 2'b01 : 2'b10;
        vectors++;
        if (req_ready !== exp_oh) begin
          miscompares++;
          $display("FAIL rr_grant%0d: got %b expected %b", g, req_ready, exp_oh);
        end
        if (last >= 0) begin
          vectors++;
          if (c - last != 3) begin
            miscompares++;
            $display("FAIL rr_spacing%0d: got %0d cycles expected 3", g, c - last);
          end
        end
        last = c;
        if (exp_oh == 2'b01) sb.push_back('{oh: 2'b01, res: 32'd7, z: 1'b0});
        else                 sb.push_back('{oh: 2'b10, res: 32'h0000_F000, z: 1'b0});
        g++;
      end
      if (rsp_valid !== 2'b00) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rr_sb_empty: got valid=%b expected none", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== e.oh || rsp_result !== e.res || rsp_zero !== e.z) begin
            miscompares++;
            $display("FAIL rr_rsp: got valid=%b result=%h zero=%b expected %b %h %b",
                     rsp_valid, rsp_result, rsp_zero, e.oh, e.res, e.z);
          end
        end
      end
      step();
    end
    req_valid = '0;
    vectors++;
    if (g != 4) begin
      miscompares++;
      $display("FAIL rr_timeout: got %0d grants expected 4", g);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rr_drain_sb_empty: got valid=%b expected none", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== e.oh || rsp_result !== e.res || rsp_zero !== e.z) begin
            miscompares++;
            $display("FAIL rr_drain_rsp: got valid=%b result=%h zero=%b expected %b %h %b",
                     rsp_valid, rsp_result, rsp_zero, e.oh, e.res, e.z);
          end
        end
      end
      step();
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL rr_leftover: got %0d pending expected 0", sb.size());
    end
    rsp_ready = '0;
  endtask

  task automatic test_withdraw();
    rsp_ready = 2'b11;
    set_req(0, 2'b00, 1'b0, 3'b000, 32'd20, 32'd22);
    req_valid = 2'b01;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL wd_grant: got %b expected 01", req_ready);
    end
    sb.push_back('{oh: 2'b01, res: 32'd42, z: 1'b0});
    step();
    set_req(1, 2'b00, 1'b0, 3'b000, 32'd1, 32'd1);
    req_valid = 2'b10;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL wd_exec_ready: got %b expected 00", req_ready);
    end
    step();
    req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid[1] !== 1'b0 || req_ready !== 2'b00) begin
        miscompares++;
        $display("FAIL wd_ghost: got valid=%b ready=%b expected x0/00", rsp_valid, req_ready);
      end
      if (rsp_valid[0] === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL wd_sb_empty: got valid=%b expected none", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== e.oh || rsp_result !== e.res || rsp_zero !== e.z) begin
            miscompares++;
            $display("FAIL wd_rsp: got valid=%b result=%h zero=%b expected %b %h %b",
                     rsp_valid, rsp_result, rsp_zero, e.oh, e.res, e.z);
          end
        end
      end
      step();
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL wd_leftover: got %0d pending expected 0", sb.size());
    end
    rsp_ready = '0;
  endtask

  task automatic test_reset_resp();
    set_req(0, 2'b10, 1'b0, 3'b110, 32'h0000_000F, 32'h0000_00F0);
    req_valid = 2'b01;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL rr2_grant: got %b expected 01", req_ready);
    end
    sb.push_back('{oh: 2'b01, res: 32'h0000_00FF, z: 1'b0});
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL rst_sb_empty: got no entry expected one");
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== e.oh || rsp_result !== e.res || rsp_zero !== e.z) begin
        miscompares++;
        $display("FAIL rst_pre_rsp: got valid=%b result=%h zero=%b expected %b %h %b",
                 rsp_valid, rsp_result, rsp_zero, e.oh, e.res, e.z);
      end
    end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(1, 2'b00, 1'b0, 3'b000, 32'd2, 32'd2);
    req_valid = 2'b11;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 2'b00 || rsp_result !== 32'd0 || alu_a !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_resp_clear: got valid=%b result=%h a=%h expected 00 0 0",
               rsp_valid, rsp_result, alu_a);
    end
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_first_grant: got %b expected 01", req_ready);
    end
    step();
    req_valid = '0;
    rsp_ready = 2'b11;
    repeat (4) step();
    rsp_ready = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    rsp_ready  = '0;
    req_aluop  = '0;
    req_funct7 = '0;
    req_funct3 = '0;
    req_a      = '0;
    req_b      = '0;
    test_reset();
    test_single();
    test_branch();
    test_round_robin();
    test_withdraw();
    test_reset_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
